// File: rtl/neuron_pe.sv
// Fixed-point neuron PE: AXI burst load of bias+weights, saturating MAC over a stream, activation.
// Optional hard-sigmoid activation is built when NEURON_PE_HSIGMOID_EN is defined.
module neuron_pe #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int FRAC_BITS  = 16,
   parameter int MAX_INPUTS = 255,
   parameter int ACC_GUARD  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_weights,
   input  logic [ADDR_WIDTH-1:0] base_addr_W,
   input  logic [7:0]            number_of_inputs,
   input  logic [1:0]            act_mode,
   output logic                  load_W_complite,
   output logic                  load_error,
   output logic                  len_error,
   output logic                  busy,
   input  logic [DATA_WIDTH-1:0] rx_tdata,
   input  logic                  rx_tvalid,
   input  logic                  rx_tlast,
   output logic                  rx_tready,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_out_valid,
   input  logic                  ready_in,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic [2:0]            m_axi_arprot,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);

   localparam int ACC_W  = DATA_WIDTH + ACC_GUARD;
   localparam int PROD_W = 2 * DATA_WIDTH;
   localparam int MEM_AW = (MAX_INPUTS < 2) ? 1 : $clog2(MAX_INPUTS + 1);

   localparam logic signed [PROD_W-1:0] P_MAX = {{(PROD_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
   localparam logic signed [PROD_W-1:0] P_MIN = {{(PROD_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
   localparam logic signed [ACC_W-1:0]  A_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0]  A_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic signed [ACC_W-1:0]  D_MAX = {{(ACC_GUARD+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0]  D_MIN = {{(ACC_GUARD+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`ifdef NEURON_PE_HSIGMOID_EN
   localparam logic signed [DATA_WIDTH:0] HS_ONE  = {{DATA_WIDTH{1'b0}}, 1'b1} << FRAC_BITS;
   localparam logic signed [DATA_WIDTH:0] HS_HALF = {{DATA_WIDTH{1'b0}}, 1'b1} << (FRAC_BITS - 1);
`endif

   typedef enum logic [1:0] {L_IDLE, L_AR, L_R} lstate_t;
   typedef enum logic [1:0] {C_ACC, C_ACT, C_OUT} cstate_t;

   function automatic logic signed [ACC_W-1:0] sat_prod(input logic signed [PROD_W-1:0] v);
      if (v > P_MAX)      sat_prod = A_MAX;
      else if (v < P_MIN) sat_prod = A_MIN;
      else                sat_prod = v[ACC_W-1:0];
   endfunction

   function automatic logic signed [ACC_W-1:0] add_sat(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [ACC_W-1:0] b);
      logic signed [ACC_W:0] s;
      s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
      if (s[ACC_W] != s[ACC_W-1]) add_sat = s[ACC_W] ? A_MIN : A_MAX;
      else                        add_sat = s[ACC_W-1:0];
   endfunction

   function automatic logic signed [DATA_WIDTH-1:0] sat_data(input logic signed [ACC_W-1:0] a);
      if (a > D_MAX)      sat_data = D_MAX[DATA_WIDTH-1:0];
      else if (a < D_MIN) sat_data = D_MIN[DATA_WIDTH-1:0];
      else                sat_data = a[DATA_WIDTH-1:0];
   endfunction

`ifdef NEURON_PE_HSIGMOID_EN
   function automatic logic signed [DATA_WIDTH-1:0] hard_sigmoid(input logic signed [DATA_WIDTH-1:0] x);
      logic signed [DATA_WIDTH:0] t;
      t = {x[DATA_WIDTH-1], x >>> 2};
      t = t + HS_HALF;
      if (t[DATA_WIDTH])  hard_sigmoid = '0;
      else if (t > HS_ONE) hard_sigmoid = HS_ONE[DATA_WIDTH-1:0];
      else                hard_sigmoid = t[DATA_WIDTH-1:0];
   endfunction
`endif

   function automatic logic signed [DATA_WIDTH-1:0] activate(input logic signed [DATA_WIDTH-1:0] x,
                                                            input logic [1:0] mode);
      case (mode)
         2'd1:    activate = x[DATA_WIDTH-1] ? '0 : x;
`ifdef NEURON_PE_HSIGMOID_EN
         2'd2:    activate = hard_sigmoid(x);
`endif
         default: activate = x;
      endcase
   endfunction

   lstate_t l_state, l_next;
   cstate_t c_state, c_next;
   logic signed [DATA_WIDTH-1:0] mem [0:MAX_INPUTS];
   logic [7:0]            n_r, bcnt;
   logic [ADDR_WIDTH-1:0] araddr_r;
   logic                  wvalid, load_acc;
   logic [8:0]            cnt;
   logic [9:0]            idx;
   logic                  beat_acc;
   logic signed [DATA_WIDTH-1:0] w_sel;
   logic signed [PROD_W-1:0]     x_ext, w_ext, prod_full, prod_sh;
   logic signed [ACC_W-1:0]      bias_ext;
   logic signed [ACC_W-1:0]      prod_p0, acc_p1;
   logic                         vld_p0, first_p0;

   assign busy          = (l_state != L_IDLE) || (c_state != C_ACC) || (cnt != '0);
   assign m_axi_araddr  = araddr_r;
   assign m_axi_arlen   = n_r;
   assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
   assign m_axi_arburst = 2'b01;
   assign m_axi_arprot  = 3'b000;

   always_comb begin
      l_next        = l_state;
      m_axi_arvalid = 1'b0;
      m_axi_rready  = 1'b0;
      load_acc      = 1'b0;
      case (l_state)
         L_IDLE: if (load_weights && !busy) begin
            load_acc = 1'b1;
            l_next   = L_AR;
         end
         L_AR: begin
            m_axi_arvalid = 1'b1;
            if (m_axi_arready) l_next = L_R;
         end
         L_R: begin
            m_axi_rready = 1'b1;
            if (m_axi_rvalid && bcnt == n_r) l_next = L_IDLE;
         end
         default: l_next = L_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         l_state         <= L_IDLE;
         n_r             <= '0;
         bcnt            <= '0;
         araddr_r        <= '0;
         wvalid          <= 1'b0;
         load_W_complite <= 1'b0;
         load_error      <= 1'b0;
      end else begin
         l_state <= l_next;
         if (load_acc) begin
            n_r             <= number_of_inputs;
            araddr_r        <= base_addr_W;
            bcnt            <= '0;
            wvalid          <= 1'b0;
            load_W_complite <= 1'b0;
            load_error      <= 1'b0;
         end
         if (l_state == L_R && m_axi_rvalid) begin
            bcnt <= bcnt + 8'd1;
            if (m_axi_rresp != 2'b00) load_error <= 1'b1;
            // error on the final beat itself must also block wvalid
            if (bcnt == n_r && m_axi_rresp == 2'b00 && !load_error) begin
               wvalid          <= 1'b1;
               load_W_complite <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (l_state == L_R && m_axi_rvalid) mem[bcnt[MEM_AW-1:0]] <= m_axi_rdata;
   end

   assign rx_tready      = (c_state == C_ACC) && wvalid && (l_state == L_IDLE);
   assign beat_acc       = rx_tvalid && rx_tready;
   assign data_out_valid = (c_state == C_OUT);
   assign idx            = {1'b0, cnt} + 10'd1;
   assign w_sel          = (idx <= {2'b00, n_r}) ? mem[idx[MEM_AW-1:0]] : '0;
   assign x_ext          = PROD_W'($signed(rx_tdata));
   assign w_ext          = PROD_W'(w_sel);
   assign prod_full      = x_ext * w_ext;
   assign prod_sh        = prod_full >>> FRAC_BITS;
   assign bias_ext       = ACC_W'(mem[0]);

   always_comb begin
      c_next = c_state;
      case (c_state)
         C_ACC:   if (beat_acc && rx_tlast) c_next = C_ACT;
         C_ACT:   if (!vld_p0) c_next = C_OUT;
         C_OUT:   if (ready_in) c_next = C_ACC;
         default: c_next = C_ACC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         c_state   <= C_ACC;
         cnt       <= '0;
         vld_p0    <= 1'b0;
         first_p0  <= 1'b0;
         len_error <= 1'b0;
         data_out  <= '0;
      end else begin
         c_state <= c_next;
         vld_p0  <= beat_acc;
         if (beat_acc) begin
            first_p0 <= (cnt == '0);
            if (rx_tlast) begin
               cnt       <= '0;
               len_error <= (idx != {2'b00, n_r});
            end else begin
               if (cnt == '0) len_error <= 1'b0;
               if (cnt != '1) cnt <= cnt + 9'd1;
            end
         end
         // p1 -> output: accumulator has absorbed the last product once vld_p0 drops
         if (c_state == C_ACT && !vld_p0) data_out <= activate(sat_data(acc_p1), act_mode);
      end
   end

   // p0: shifted product saturated to accumulator width; p1: saturating accumulate
   always_ff @(posedge clk) begin
      if (beat_acc) prod_p0 <= sat_prod(prod_sh);
      if (vld_p0)   acc_p1  <= first_p0 ? add_sat(bias_ext, prod_p0) : add_sat(acc_p1, prod_p0);
   end

endmodule

// File: tb/tb_neuron_pe.sv
// Testbench for neuron_pe: directed test-plan cases plus randomized vectors checked
// against an arithmetic reference model; AXI slave responses are driven inline.
module tb_neuron_pe;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_weights;
   logic [31:0] base_addr_W;
   logic [7:0]  number_of_inputs;
   logic [1:0]  act_mode;
   logic        load_W_complite, load_error, len_error, busy;
   logic [31:0] rx_tdata;
   logic        rx_tvalid, rx_tlast, rx_tready;
   logic [31:0] data_out;
   logic        data_out_valid, ready_in;
   logic [31:0] m_axi_araddr;
   logic [7:0]  m_axi_arlen;
   logic [2:0]  m_axi_arsize;
   logic [1:0]  m_axi_arburst;
   logic [2:0]  m_axi_arprot;
   logic        m_axi_arvalid, m_axi_arready;
   logic [31:0] m_axi_rdata;
   logic [1:0]  m_axi_rresp;
   logic        m_axi_rvalid, m_axi_rready;

   always #5 clk = ~clk;

   neuron_pe dut (
      .clk(clk), .rst(rst), .load_weights(load_weights), .base_addr_W(base_addr_W),
      .number_of_inputs(number_of_inputs), .act_mode(act_mode),
      .load_W_complite(load_W_complite), .load_error(load_error), .len_error(len_error),
      .busy(busy), .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast),
      .rx_tready(rx_tready), .data_out(data_out), .data_out_valid(data_out_valid),
      .ready_in(ready_in), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arprot(m_axi_arprot),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata),
      .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   int checks = 0;
   int failures = 0;
   logic [31:0] tb_mem [0:15];
   logic [31:0] vin [0:15];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic longint clampl(input longint v, input longint lo, input longint hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   // Reference: bias + sum of (x*w)>>>16 with weights past N treated as zero,
   // saturated to a 40-bit accumulator, then to 32 bits, then the activation.
   function automatic logic [31:0] model(input int nb, input int n, input logic [1:0] mode);
      longint amax, amin, acc, p, w;
      int x;
      amax = (longint'(1) << 39) - 1;
      amin = -(longint'(1) << 39);
      acc  = longint'($signed(tb_mem[0]));
      for (int i = 1; i <= nb; i++) begin
         w   = (i <= n) ? longint'($signed(tb_mem[i])) : 64'sd0;
         p   = (longint'($signed(vin[i-1])) * w) >>> 16;
         acc = clampl(acc + clampl(p, amin, amax), amin, amax);
      end
      x = int'(clampl(acc, -64'sd2147483648, 64'sd2147483647));
      if (mode == 2'd1 && x < 0) x = 0;
`ifdef NEURON_PE_HSIGMOID_EN
      if (mode == 2'd2) x = int'(clampl(longint'((x >>> 2) + 32768), 0, 65536));
`endif
      return x;
   endfunction

   task automatic do_load(input int n, input logic [31:0] base, input int err_beat);
      load_weights = 1'b1; base_addr_W = base; number_of_inputs = 8'(n);
      tick();
      load_weights = 1'b0;
      chk("ar_valid", 32'(m_axi_arvalid), 1);
      chk("ar_addr", m_axi_araddr, base);
      chk("ar_len", 32'(m_axi_arlen), n);
      chk("ar_size_burst_prot", {24'd0, m_axi_arsize, m_axi_arburst, m_axi_arprot}, {24'd0, 3'd2, 2'b01, 3'd0});
      chk("rready_during_ar", 32'(m_axi_rready), 0);
      repeat ($urandom_range(0, 2)) tick();
      m_axi_arready = 1'b1;
      tick();
      m_axi_arready = 1'b0;
      chk("ar_drop", 32'(m_axi_arvalid), 0);
      for (int k = 0; k <= n; k++) begin
         repeat ($urandom_range(0, 1)) tick();
         m_axi_rvalid = 1'b1;
         m_axi_rdata  = tb_mem[k];
         m_axi_rresp  = (k == err_beat) ? 2'b10 : 2'b00;
         chk("r_ready", 32'(m_axi_rready), 1);
         tick();
         m_axi_rvalid = 1'b0;
         m_axi_rresp  = 2'b00;
      end
      chk("r_done", 32'(m_axi_rready), 0);
      chk("load_complete", 32'(load_W_complite), (err_beat < 0) ? 1 : 0);
      chk("load_error", 32'(load_error), (err_beat < 0) ? 0 : 1);
   endtask

   task automatic run_vec(input string tag, input int nb, input logic [1:0] mode,
                          input logic [31:0] exp, input bit exp_len, input int hold);
      act_mode = mode;
      for (int i = 0; i < nb; i++) begin
         int b = 0;
         rx_tdata = vin[i]; rx_tvalid = 1'b1; rx_tlast = (i == nb - 1);
         while (!rx_tready && b < 10) begin tick(); b++; end
         chk({tag, "_tready"}, 32'(rx_tready), 1);
         tick();
      end
      rx_tvalid = 1'b0; rx_tlast = 1'b0;
      tick();
      chk({tag, "_lat1"}, 32'(data_out_valid), 0);
      tick();
      chk({tag, "_lat2"}, 32'(data_out_valid), 1);
      chk({tag, "_data"}, data_out, exp);
      chk({tag, "_len"}, 32'(len_error), 32'(exp_len));
      for (int h = 0; h < hold; h++) begin
         load_weights = (h == 1);
         tick();
         load_weights = 1'b0;
         chk({tag, "_hold_data"}, data_out, exp);
         chk({tag, "_hold_ctl"}, {29'd0, data_out_valid, busy, rx_tready}, {29'd0, 3'b110});
         chk({tag, "_hold_noload"}, 32'(m_axi_arvalid), 0);
      end
      ready_in = 1'b1;
      tick();
      ready_in = 1'b0;
      chk({tag, "_done_valid"}, 32'(data_out_valid), 0);
      chk({tag, "_done_tready"}, 32'(rx_tready), 1);
   endtask

   task automatic set_ident(input logic [31:0] bias);
      tb_mem[0] = bias; tb_mem[1] = 32'h0001_0000; tb_mem[2] = 32'h0002_0000; tb_mem[3] = 32'hFFFF_0000;
      for (int i = 0; i < 16; i++) vin[i] = 32'h0001_0000;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] hs_a, hs_b, e;
      int n, nb;
      logic [1:0] md;
      rst = 1'b1; load_weights = 1'b0; base_addr_W = '0; number_of_inputs = '0; act_mode = '0;
      rx_tdata = '0; rx_tvalid = 1'b0; rx_tlast = 1'b0; ready_in = 1'b0;
      m_axi_arready = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rvalid = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_data_out", data_out, 0);
      chk("rst_ctl", {24'd0, data_out_valid, m_axi_arvalid, m_axi_rready, rx_tready,
                      load_W_complite, load_error, len_error, busy}, 0);

      // identity MAC
      set_ident(32'h0001_0000);
      do_load(3, 32'h0000_1000, -1);
      run_vec("ident", 3, 2'd0, 32'h0003_0000, 1'b0, 0);

      // ReLU with negative sum
      set_ident(32'hFFFC_0000);
      do_load(3, 32'h0000_2000, -1);
      run_vec("relu", 3, 2'd1, 32'h0000_0000, 1'b0, 0);
      run_vec("relu_ident", 3, 2'd0, 32'hFFFE_0000, 1'b0, 0);

      // hard sigmoid (identity when the feature is not built)
`ifdef NEURON_PE_HSIGMOID_EN
      hs_a = 32'h0001_0000; hs_b = 32'h0000_C000;
`else
      hs_a = 32'h0003_0000; hs_b = 32'h0001_0000;
`endif
      set_ident(32'h0001_0000);
      do_load(3, 32'h0000_3000, -1);
      run_vec("hsig_clamp", 3, 2'd2, hs_a, 1'b0, 0);
      set_ident(32'hFFFF_0000);
      do_load(3, 32'h0000_3000, -1);
      run_vec("hsig_mid", 3, 2'd2, hs_b, 1'b0, 0);

      // saturation both directions
      tb_mem[0] = 32'h0; tb_mem[1] = 32'h7FFF_0000; tb_mem[2] = 32'h7FFF_0000;
      do_load(2, 32'h0000_4000, -1);
      vin[0] = 32'h7FFF_0000; vin[1] = 32'h7FFF_0000;
      run_vec("sat_pos", 2, 2'd0, 32'h7FFF_FFFF, 1'b0, 0);
      vin[0] = 32'h8001_0000; vin[1] = 32'h8001_0000;
      run_vec("sat_neg", 2, 2'd0, 32'h8000_0000, 1'b0, 0);

      // load error on beat 1: all beats consumed, no compute allowed
      set_ident(32'h0001_0000);
      do_load(3, 32'h0000_5000, 1);
      tick();
      chk("lderr_tready", 32'(rx_tready), 0);
      chk("lderr_busy", 32'(busy), 0);

      // length mismatch (short, then long) with back-pressure, then a clean vector
      do_load(3, 32'h0000_6000, -1);
      run_vec("short", 2, 2'd0, 32'h0004_0000, 1'b1, 5);
      vin[3] = 32'h1234_5678; vin[4] = 32'hDEAD_BEEF;
      run_vec("long", 5, 2'd0, 32'h0003_0000, 1'b1, 0);
      for (int i = 0; i < 16; i++) vin[i] = 32'h0001_0000;
      run_vec("len_ok", 3, 2'd0, 32'h0003_0000, 1'b0, 0);

      // randomized vectors against the reference model
      for (int t = 0; t < 8; t++) begin
         n = $urandom_range(1, 8);
         for (int i = 0; i <= 9; i++)
            tb_mem[i] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 32'h000F_FFFF)) - 32'h0008_0000;
         for (int i = 0; i < 10; i++)
            vin[i] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 32'h000F_FFFF)) - 32'h0008_0000;
         nb = n + $urandom_range(0, 2) - 1;
         if (nb < 1) nb = 1;
         md = 2'($urandom_range(0, 3));
         do_load(n, $urandom & 32'hFFFF_FFFC, -1);
         e = model(nb, n, md);
         run_vec("rand", nb, md, e, nb != n, $urandom_range(0, 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/neuron_pe.md
# neuron_pe

Parametrised fixed-point neuron processing element: loads bias and weights from memory over an AXI read burst into local storage. It then computes a saturating multiply-accumulate over an AXIS-style input vector and applies a selectable activation. It is the next-generation per-neuron compute unit of the coprocessor layer array, adding configurable width, fraction bits, depth, bias, saturation, activation modes and error reporting.

## Interface
- DATA_WIDTH, 32: width of data, weights, bias and result (signed fixed point).
- ADDR_WIDTH, 32: AXI address width.
- FRAC_BITS, 16: fractional bits of the fixed-point format (1 ≤ FRAC_BITS < DATA_WIDTH-1).
- MAX_INPUTS, 255: weight memory depth (≤ 255); the memory holds MAX_INPUTS+1 words (bias and weights).
- ACC_GUARD, 8: accumulator guard bits; the accumulator is DATA_WIDTH+ACC_GUARD wide.
- clk  in  1  clock; everything is synchronous to posedge clk.
- rst  in  1  synchronous active-high reset.
- load_weights  in  1  load request; accepted only while busy=0.
- base_addr_W  in  ADDR_WIDTH  byte address of the bias word.
- number_of_inputs  in  8  N, the number of inputs (1..MAX_INPUTS); sampled on load accept.
- act_mode  in  2  activation: 0 identity, 1 ReLU, 2 hard sigmoid, 3 identity.
- load_W_complite  out  1  level; weights loaded without error.
- load_error  out  1  sticky; a non-OKAY rresp occurred in the last load.
- len_error  out  1  sticky; the last vector length was not N.
- busy  out  1  a load is in flight, or a vector is partly accepted, or a result is pending.
- rx_tdata  in  DATA_WIDTH  input activation.
- rx_tvalid  in  1  input beat valid.
- rx_tlast  in  1  last beat of the vector.
- rx_tready  out  1  input beat ready.
- data_out  out  DATA_WIDTH  activated result.
- data_out_valid  out  1  result valid.
- ready_in  in  1  downstream ready.
- m_axi_araddr/arlen/arsize/arburst/arprot/arvalid  out  ADDR_WIDTH/8/3/2/3/1  AXI read address channel.
- m_axi_arready  in  1.
- m_axi_rdata  in  DATA_WIDTH.
- m_axi_rresp  in  2.
- m_axi_rvalid  in  1.
- m_axi_rready  out  1.

## Operation
- **Load FSM L_IDLE→L_AR→L_R→L_IDLE.**
  - On load accept: clear load_W_complite, load_error and the internal wvalid; capture N.
  - Drive araddr=base_addr_W, arlen=N (N+1 beats), arsize=$clog2(DATA_WIDTH/8), arburst=2'b01 (INCR), arprot=0.
  - In L_AR, arvalid=1 until arready is seen.
  - In L_R, rready=1. Beat k writes mem[k]; beat 0 is the bias, beats 1..N are w1..wN. Beats are counted, not signalled by rlast.
  - At the end of the beat that has index N: go to L_IDLE. If load_error=0, set wvalid and load_W_complite.
  - Any rresp≠0 sets load_error; the remaining beats are still consumed.
- **Compute FSM C_ACC→C_ACT→C_OUT→C_ACC.**
  - rx_tready=1 only in C_ACC with wvalid=1 and the load FSM in L_IDLE.
  - On the first beat the accumulator is seeded with the sign-extended bias.
  - Beat i (1-based) adds (rx_tdata × w_i)>>>FRAC_BITS. The product is full 2·DATA_WIDTH signed, arithmetic shift, truncated toward −∞.
  - Beats with i>N use weight 0.
  - On the tlast beat: if the beat count ≠ N, set len_error (cleared at the first beat of the next vector). Then go to C_ACT.
- **C_ACT** saturates the accumulator to the signed DATA_WIDTH range, then applies the activation:
  - ReLU: max(x,0).
  - Hard sigmoid: clamp((x>>>2)+2^(FRAC_BITS−1), 0, 2^FRAC_BITS).
- **C_OUT** holds data_out with data_out_valid=1 until ready_in=1, then goes to C_ACC.
- **Load request while busy=1:** ignored, not queued.
- **Reset values:**
  - All outputs are 0 (data_out=0, arvalid=0, rready=0, rx_tready=0, all flags 0).
  - wvalid=0; the FSMs go to L_IDLE/C_ACC.
  - Memory contents are undefined.
- **Reset mid-burst** abandons the burst; the interconnect is reset together with the block.

## Timing
- One input beat is accepted per cycle, with no bubbles inside a vector.
- Latency: if the tlast beat is accepted at edge k, data_out_valid is 1 from edge k+2.
- The result handshake completes on the edge where valid&ready_in. rx_tready returns high in the following cycle, so a new vector can start one cycle after the handshake.
- Load: arvalid rises on the edge after load accept. load_W_complite rises on the edge that accepts the final R beat.
- The address channel and data channel are never active simultaneously: rready is asserted only after the AR handshake.

## Configuration
- NEURON_PE_HSIGMOID_EN defined: act_mode=2 selects hard sigmoid.
- NEURON_PE_HSIGMOID_EN undefined: the hard-sigmoid logic is not built and act_mode=2 behaves as identity.

## Test plan
All values use FRAC_BITS=16; 1.0 = 0x0001_0000.

- **Identity MAC:** load N=3 with bias 1.0 and w=1.0, 2.0, −1.0; inputs 1.0, 1.0, 1.0 with tlast on beat 3, act_mode=0 → data_out=0x0003_0000, valid at tlast edge+2, len_error=0.
- **ReLU:** same weights but bias −4.0, act_mode=1 → data_out=0; with act_mode=0 → 0xFFFE_0000.
- **Hard sigmoid** (macro defined): identity case with act_mode=2 → 0x0001_0000 (clamped). With bias −1.0 (sum 1.0) → 0x0000_C000.
- **Saturation:** N=2, bias 0, w=0x7FFF_0000 twice, inputs 0x7FFF_0000, act_mode=0 → 0x7FFF_FFFF. With negated inputs → 0x8000_0000.
- **Load error:** rresp=2'b10 on beat 1 of an N=3 load → load_error=1, load_W_complite=0, 4 beats consumed, rx_tready stays 0.
- **Length mismatch and back-pressure:** N=3 with tlast on beat 2 → len_error=1 and data_out = bias+2 products. Hold ready_in=0 for 5 cycles → data_out stable, rx_tready=0, busy=1, load_weights ignored.
